pixel_stream_feeder: RTL and testbench
======================================

Name: pixel_stream_feeder

Overview:
- Master side of the pixel-input handshake of facial_detection_ip.
- Reads a stored greyscale frame from a synchronous image memory (ROM/BRAM, 1-cycle read latency) in raster order.
- Presents one pixel per handshake on pixel/end_recieve_pixel, gated by the detector's o_ready_recieve_pixel.
- Tracks frame position, and on the detector's o_end_frame closes out the frame or aborts the stream.

Parameters:
- DATA_WIDTH, 12: pixel width.
- ADDR_WIDTH, 17: image memory address width. FRAME_WIDTH*FRAME_HEIGHT must be <= 2^ADDR_WIDTH.
- COORD_WIDTH, 12: x/y counter width.
- FRAME_WIDTH, 320: pixels per row.
- FRAME_HEIGHT, 240: rows per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request to stream one frame; sampled only in IDLE
- mem_rd  out  1  image memory read enable
- mem_addr  out  ADDR_WIDTH  image memory read address
- mem_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd
- ready_recieve_pixel  in  1  detector ready (from o_ready_recieve_pixel)
- end_frame  in  1  detector end-of-frame (from o_end_frame)
- pixel  out  DATA_WIDTH  current pixel value
- end_recieve_pixel  out  1  one-cycle strobe: pixel valid and transferred
- o_x  out  COORD_WIDTH  column of the pixel currently held
- o_y  out  COORD_WIDTH  row of the pixel currently held
- o_busy  out  1  high in every state except IDLE
- o_frame_done  out  1  one-cycle pulse at frame close-out
- o_aborted  out  1  sticky; set when end_frame arrives before the last pixel is sent, cleared by the next accepted start or by reset

Behaviour:
- Reset (synchronous, highest priority, any state):
  - state = IDLE.
  - All outputs 0: pixel, mem_addr, o_x, o_y, mem_rd, end_recieve_pixel, o_busy, o_frame_done, o_aborted.
  - Internal pixel counter = 0.
  - Reset mid-frame discards all progress.
- FSM states: IDLE, FETCH, WAIT_DATA, WAIT_READY, SEND, DRAIN.
- Outputs are decoded from registered state only (Moore):
  - mem_rd = (state == FETCH).
  - end_recieve_pixel = (state == SEND).
  - o_busy = (state != IDLE).
- IDLE:
  - start = 1 → FETCH; mem_addr, o_x, o_y and the counter cleared to 0; o_aborted cleared.
  - end_frame in IDLE is ignored.
- FETCH: one cycle with mem_rd = 1 → WAIT_DATA.
- WAIT_DATA: pixel <= mem_data at the end of this cycle → WAIT_READY.
- WAIT_READY:
  - Stays here while ready_recieve_pixel = 0; pixel and o_x/o_y stay stable.
  - ready_recieve_pixel = 1 → SEND.
- SEND:
  - end_recieve_pixel = 1 for exactly one cycle.
  - Advance position at the end of the cycle:
    - if o_x == FRAME_WIDTH-1: o_x <= 0 and o_y <= o_y+1;
    - else o_x <= o_x+1.
    - mem_addr <= mem_addr+1; counter <= counter+1.
  - Next state: if counter == FRAME_WIDTH*FRAME_HEIGHT-1 → DRAIN (o_x/o_y/mem_addr hold last-pixel values, no wrap); else → FETCH.
- DRAIN: wait for end_frame = 1, then pulse o_frame_done for one cycle → IDLE.
- Latency and throughput:
  - start sampled in cycle N → first end_recieve_pixel strobe in cycle N+4 (ready held high).
  - With ready held high, one strobe every 4 cycles.
- Abort:
  - end_frame = 1 in FETCH, WAIT_DATA, WAIT_READY or SEND → next state IDLE.
  - o_frame_done pulses for one cycle and o_aborted is set.
  - If end_frame coincides with SEND, the strobe for that cycle is still issued; no position advance follows.
- Simultaneous end_frame and the last-pixel SEND: treated as a normal completion → DRAIN, o_aborted = 0; DRAIN then needs a fresh end_frame.
- start while busy is ignored.
- Arithmetic: counters are unsigned, no saturation needed within the parameter constraint.

Test Plan:
- Use FRAME_WIDTH=4, FRAME_HEIGHT=3; memory word k holds 10+k.
- Reset held for 3 cycles mid-SEND → next cycle all outputs 0, state IDLE, o_busy = 0.
- start pulse, ready tied high → 12 strobes spaced 4 cycles apart, first at start+4.
  - Pixels 10..21 in order.
  - (o_x,o_y) follows (0,0),(1,0),(2,0),(3,0),(0,1),…,(3,2).
  - Then DRAIN; end_frame pulse → o_frame_done = 1 for one cycle, o_aborted = 0, o_busy = 0.
- ready low for 7 cycles while in WAIT_READY on pixel 5 → no strobe, pixel stays 15, (o_x,o_y) = (1,1); strobe one cycle after ready rises.
- end_frame asserted after the 6th strobe (in FETCH) → IDLE next cycle, o_frame_done pulses, o_aborted = 1; a new start clears o_aborted and restarts at pixel 10, (0,0).
- end_frame in the same cycle as the 12th SEND → strobe issued with pixel 21, enters DRAIN, o_aborted = 0.
- start pulses during streaming, and end_frame in IDLE → no effect on the sequence or on outputs.

Source files
------------

// File: rtl/pixel_stream_feeder.sv
// pixel_stream_feeder: reads a stored frame from synchronous image memory in raster order
// and hands it pixel by pixel to the facial detector's pixel-input handshake.
module pixel_stream_feeder #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDR_WIDTH   = 17,
    parameter int COORD_WIDTH  = 12,
    parameter int FRAME_WIDTH  = 320,
    parameter int FRAME_HEIGHT = 240
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   mem_rd,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [DATA_WIDTH-1:0]  mem_data,
    input  logic                   ready_recieve_pixel,
    input  logic                   end_frame,
    output logic [DATA_WIDTH-1:0]  pixel,
    output logic                   end_recieve_pixel,
    output logic [COORD_WIDTH-1:0] o_x,
    output logic [COORD_WIDTH-1:0] o_y,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_aborted
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT_DATA, WAIT_READY, SEND, DRAIN} state_t;

    localparam logic [ADDR_WIDTH-1:0]  LAST_PIXEL = ADDR_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT - 1);
    localparam logic [COORD_WIDTH-1:0] LAST_COL   = COORD_WIDTH'(FRAME_WIDTH - 1);

    state_t                state, next;
    logic [ADDR_WIDTH-1:0] count;
    logic                  last, abort, close;

    assign last              = (count == LAST_PIXEL);
    assign mem_rd            = (state == FETCH);
    assign end_recieve_pixel = (state == SEND);
    assign o_busy            = (state != IDLE);

    always_comb begin
        next = state;
        case (state)
            IDLE:       next = start ? FETCH : IDLE;
            FETCH:      next = end_frame ? IDLE : WAIT_DATA;
            WAIT_DATA:  next = end_frame ? IDLE : WAIT_READY;
            WAIT_READY: next = end_frame ? IDLE : (ready_recieve_pixel ? SEND : WAIT_READY);
            // the last pixel always completes normally, even if end_frame coincides
            SEND:       next = last ? DRAIN : (end_frame ? IDLE : FETCH);
            DRAIN:      next = end_frame ? IDLE : DRAIN;
            default:    next = IDLE;
        endcase
    end

    assign abort = (next == IDLE) && (state != IDLE) && (state != DRAIN);
    assign close = abort || (state == DRAIN && end_frame);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            mem_addr     <= '0;
            pixel        <= '0;
            o_x          <= '0;
            o_y          <= '0;
            o_frame_done <= 1'b0;
            o_aborted    <= 1'b0;
        end else begin
            state        <= next;
            o_frame_done <= close;
            if (state == IDLE && start) begin
                count     <= '0;
                mem_addr  <= '0;
                o_x       <= '0;
                o_y       <= '0;
                o_aborted <= 1'b0;
            end
            if (abort) o_aborted <= 1'b1;
            if (state == WAIT_DATA) pixel <= mem_data;
            if (state == SEND && next == FETCH) begin
                count    <= count + 1'b1;
                mem_addr <= mem_addr + 1'b1;
                o_x      <= (o_x == LAST_COL) ? '0 : o_x + 1'b1;
                o_y      <= (o_x == LAST_COL) ? o_y + 1'b1 : o_y;
            end
        end
    end
endmodule

// File: tb/tb_pixel_stream_feeder.sv
// tb_pixel_stream_feeder: scenario tasks checking the feeder against a raster-order model
// of a 4x3 frame whose memory word k holds 10+k.
module tb_pixel_stream_feeder;
    localparam int DW = 12, AW = 17, CW = 12, FW = 4, FH = 3, NPIX = FW * FH;

    logic          clk = 0, reset = 1, start = 0, ready = 0, end_frame = 0;
    logic          mem_rd, erp, busy, fdone, aborted;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data = '0, pixel;
    logic [CW-1:0] ox, oy;
    int            n_pass = 0, n_total = 0;

    pixel_stream_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COORD_WIDTH(CW),
                          .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
        .clk(clk), .reset(reset), .start(start), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_data(mem_data), .ready_recieve_pixel(ready), .end_frame(end_frame),
        .pixel(pixel), .end_recieve_pixel(erp), .o_x(ox), .o_y(oy), .o_busy(busy),
        .o_frame_done(fdone), .o_aborted(aborted)
    );

    always #5 clk = ~clk;

    // image memory: one-cycle read latency
    always @(posedge clk) if (mem_rd) mem_data <= DW'(10 + int'(mem_addr));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1; start = 0; ready = 0; end_frame = 0;
        tick; tick;
        reset = 0;
    endtask

    task automatic test_reset;
        do_reset;
        ready = 1; start = 1; tick; start = 0;
        for (int i = 0; i < 8 && erp !== 1'b1; i++) tick;
        n_total++;
        if (erp !== 1'b1) $display("FAIL reset_reach_send: strobe=%b required 1", erp); else n_pass++;
        reset = 1; tick; tick; tick;
        n_total++;
        if ({pixel, mem_addr, ox, oy, mem_rd, erp, busy, fdone, aborted} !== '0)
            $display("FAIL reset_outputs: pix=%0d addr=%0d x=%0d y=%0d rd=%b strb=%b busy=%b done=%b ab=%b required all 0",
                     pixel, mem_addr, ox, oy, mem_rd, erp, busy, fdone, aborted);
        else n_pass++;
        reset = 0; ready = 0; tick;
        n_total++;
        if ({mem_rd, erp, busy, fdone, aborted, pixel} !== '0)
            $display("FAIL reset_stays_idle: rd=%b strb=%b busy=%b done=%b ab=%b pix=%0d required 0",
                     mem_rd, erp, busy, fdone, aborted, pixel);
        else n_pass++;
    endtask

    task automatic test_full_frame;
        int k = 0, cyc;
        do_reset;
        ready = 1; start = 1; tick; start = 0; cyc = 1;
        while (k < NPIX && cyc < 100) begin
            if (erp === 1'b1) begin
                n_total++;
                if ({pixel, ox, oy} !== {DW'(10 + k), CW'(k % FW), CW'(k / FW)} || cyc != 4 + 4 * k)
                    $display("FAIL full_strobe%0d: pix=%0d x=%0d y=%0d cyc=%0d required pix=%0d x=%0d y=%0d cyc=%0d",
                             k, pixel, ox, oy, cyc, 10 + k, k % FW, k / FW, 4 + 4 * k);
                else n_pass++;
                k++;
            end
            tick; cyc++;
        end
        n_total++;
        if (k != NPIX) $display("FAIL full_count: strobes=%0d required %0d", k, NPIX); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({busy, erp, fdone, ox, oy, mem_addr} !== {1'b1, 1'b0, 1'b0, CW'(FW - 1), CW'(FH - 1), AW'(NPIX - 1)})
                $display("FAIL full_drain: busy=%b strb=%b done=%b x=%0d y=%0d addr=%0d required 1 0 0 %0d %0d %0d",
                         busy, erp, fdone, ox, oy, mem_addr, FW - 1, FH - 1, NPIX - 1);
            else n_pass++;
            tick;
        end
        end_frame = 1; tick; end_frame = 0;
        n_total++;
        if ({fdone, aborted, busy} !== 3'b100)
            $display("FAIL full_close: done=%b ab=%b busy=%b required 1 0 0", fdone, aborted, busy);
        else n_pass++;
        tick;
        n_total++;
        if ({fdone, busy} !== 2'b00) $display("FAIL full_done_pulse: done=%b busy=%b required 0 0", fdone, busy);
        else n_pass++;
    endtask

    task automatic test_ready_stall;
        int k = 0;
        do_reset;
        ready = 1; start = 1; tick; start = 0;
        for (int c = 0; c < 100 && k < 5; c++) begin
            tick;
            if (erp === 1'b1) k++;
        end
        n_total++;
        if (k != 5) $display("FAIL stall_setup: strobes=%0d required 5", k); else n_pass++;
        ready = 0;
        tick; tick; tick;
        for (int i = 0; i < 7; i++) begin
            n_total++;
            if ({erp, pixel, ox, oy} !== {1'b0, DW'(15), CW'(1), CW'(1)})
                $display("FAIL stall_hold%0d: strb=%b pix=%0d x=%0d y=%0d required 0 15 1 1", i, erp, pixel, ox, oy);
            else n_pass++;
            tick;
        end
        ready = 1; tick;
        n_total++;
        if ({erp, pixel, ox, oy} !== {1'b1, DW'(15), CW'(1), CW'(1)})
            $display("FAIL stall_release: strb=%b pix=%0d x=%0d y=%0d required 1 15 1 1", erp, pixel, ox, oy);
        else n_pass++;
    endtask

    task automatic test_abort;
        int k = 0, cyc = 1;
        do_reset;
        ready = 1; start = 1; tick; start = 0;
        for (int c = 0; c < 100 && k < 6; c++) begin
            tick;
            if (erp === 1'b1) k++;
        end
        tick;
        end_frame = 1; tick; end_frame = 0;
        n_total++;
        if ({busy, fdone, aborted} !== 3'b011)
            $display("FAIL abort_close: busy=%b done=%b ab=%b strobes=%0d required 0 1 1", busy, fdone, aborted, k);
        else n_pass++;
        tick;
        n_total++;
        if ({busy, fdone, aborted} !== 3'b001)
            $display("FAIL abort_sticky: busy=%b done=%b ab=%b required 0 0 1", busy, fdone, aborted);
        else n_pass++;
        start = 1; tick; start = 0;
        n_total++;
        if ({aborted, busy, ox, oy, mem_addr} !== {1'b0, 1'b1, CW'(0), CW'(0), AW'(0)})
            $display("FAIL abort_restart: ab=%b busy=%b x=%0d y=%0d addr=%0d required 0 1 0 0 0",
                     aborted, busy, ox, oy, mem_addr);
        else n_pass++;
        while (erp !== 1'b1 && cyc < 20) begin tick; cyc++; end
        n_total++;
        if ({erp, pixel, ox, oy} !== {1'b1, DW'(10), CW'(0), CW'(0)} || cyc != 4)
            $display("FAIL abort_first_pixel: strb=%b pix=%0d x=%0d y=%0d cyc=%0d required 1 10 0 0 4",
                     erp, pixel, ox, oy, cyc);
        else n_pass++;
    endtask

    task automatic test_end_at_last;
        int k = 0;
        do_reset;
        ready = 1; start = 1; tick; start = 0;
        for (int c = 0; c < 100 && k < NPIX - 1; c++) begin
            tick;
            if (erp === 1'b1) k++;
        end
        tick; tick; tick; tick;
        n_total++;
        if ({erp, pixel, ox, oy} !== {1'b1, DW'(21), CW'(3), CW'(2)})
            $display("FAIL last_strobe: strb=%b pix=%0d x=%0d y=%0d required 1 21 3 2", erp, pixel, ox, oy);
        else n_pass++;
        end_frame = 1; tick; end_frame = 0;
        n_total++;
        if ({busy, fdone, aborted, erp} !== 4'b1000)
            $display("FAIL last_drain: busy=%b done=%b ab=%b strb=%b required 1 0 0 0", busy, fdone, aborted, erp);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_total++;
            if ({busy, fdone} !== 2'b10) $display("FAIL last_wait%0d: busy=%b done=%b required 1 0", i, busy, fdone);
            else n_pass++;
        end
        end_frame = 1; tick; end_frame = 0;
        n_total++;
        if ({fdone, busy, aborted} !== 3'b100)
            $display("FAIL last_close: done=%b busy=%b ab=%b required 1 0 0", fdone, busy, aborted);
        else n_pass++;
    endtask

    task automatic test_random;
        do_reset;
        end_frame = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_total++;
            if ({busy, fdone, aborted, erp, mem_rd} !== 5'b0)
                $display("FAIL idle_end_frame%0d: busy=%b done=%b ab=%b strb=%b rd=%b required 0",
                         i, busy, fdone, aborted, erp, mem_rd);
            else n_pass++;
        end
        end_frame = 0;
        for (int r = 0; r < 3; r++) begin
            int k = 0, cyc = 1, prev = -10;
            start = 1; tick; start = 0;
            while (k < NPIX && cyc < 2000) begin
                ready = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
                tick; cyc++;
                if (erp === 1'b1) begin
                    n_total++;
                    if ({pixel, ox, oy, aborted} !== {DW'(10 + k), CW'(k % FW), CW'(k / FW), 1'b0} || cyc - prev < 4)
                        $display("FAIL rand%0d_strobe%0d: pix=%0d x=%0d y=%0d ab=%b gap=%0d required pix=%0d x=%0d y=%0d ab=0 gap>=4",
                                 r, k, pixel, ox, oy, aborted, cyc - prev, 10 + k, k % FW, k / FW);
                    else n_pass++;
                    prev = cyc; k++;
                end
            end
            n_total++;
            if (k != NPIX) $display("FAIL rand%0d_count: strobes=%0d required %0d", r, k, NPIX); else n_pass++;
            start = 1;
            for (int i = 0; i < 4; i++) tick;
            n_total++;
            if ({busy, erp, fdone} !== 3'b100)
                $display("FAIL rand%0d_drain: busy=%b strb=%b done=%b required 1 0 0", r, busy, erp, fdone);
            else n_pass++;
            start = 0; end_frame = 1; tick; end_frame = 0;
            n_total++;
            if ({fdone, busy} !== 2'b10) $display("FAIL rand%0d_close: done=%b busy=%b required 1 0", r, fdone, busy);
            else n_pass++;
            tick;
            n_total++;
            if ({busy, fdone} !== 2'b00) $display("FAIL rand%0d_idle: busy=%b done=%b required 0 0", r, busy, fdone);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_full_frame;
        test_ready_stall;
        test_abort;
        test_end_at_last;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
